// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: counting modes and an elaboration-time
// ceiling log2 used to size internal registers.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int              bits;
        v    = (value > 0) ? value - 1 : 0;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    // Register width needed to hold 0..count-1; never below one bit.
    function automatic int width_for(input longint unsigned count);
        int bits;
        bits = clog2(count);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage : counter_pkg

// File: rtl/sync_updown_counter_tick_prescaler.sv
// Enable prescaler: emits a single-cycle tick on every PRESCALE-th clock that has en high.
// The phase freezes while en is low and restarts from zero on clr.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW      = width_for(PRESCALE);
    localparam logic [CW-1:0] LP_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LP_LAST);
    assign tick      = en && w_at_last;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the values present before the edge regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : tick_prescaler

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with programmable modulus, parallel load,
// wrap or saturate mode, prescaled enable, terminal count, carry pulse and sticky overflow.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     PRESCALE = 1,
    parameter int     SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             carry,
    output logic             ovf
);

    localparam int             EW        = WIDTH + 1;
    localparam logic [EW-1:0]  LP_MOD    = EW'(MODULUS);
    localparam logic [EW-1:0]  LP_MAX    = EW'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LP_MAX_Q = LP_MAX[WIDTH-1:0];
    localparam bit             LP_SAT    = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             r_ovf;

    logic             w_tick;
    logic [EW-1:0]    w_q_ext;
    logic [EW-1:0]    w_din_ext;
    logic [EW-1:0]    w_inc;
    logic [EW-1:0]    w_dec;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_load_val;

    // Load also restarts the prescaler phase, so both requests clear it.
    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign w_tick = t;
        end else begin : g_prescale
            tick_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr | load),
                .en    (t),
                .tick  (w_tick)
            );
        end
    endgenerate

    assign w_q_ext    = {1'b0, r_q};
    assign w_din_ext  = {1'b0, din};
    assign w_inc      = w_q_ext + 1'b1;
    assign w_dec      = w_q_ext - 1'b1;
    assign w_at_max   = (w_q_ext == LP_MAX);
    assign w_at_zero  = (w_q_ext == '0);
    assign w_load_val = (w_din_ext < LP_MOD) ? din : LP_MAX_Q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_q     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_q     <= w_load_val;
            r_carry <= 1'b0;
        end else if (w_tick) begin
            if (up) begin
                if (w_at_max) begin
                    r_q     <= LP_SAT ? r_q : '0;
                    r_carry <= 1'b1;
                    r_ovf   <= 1'b1;
                end else begin
                    r_q     <= w_inc[WIDTH-1:0];
                    r_carry <= 1'b0;
                end
            end else begin
                if (w_at_zero) begin
                    r_q     <= LP_SAT ? r_q : LP_MAX_Q;
                    r_carry <= 1'b1;
                    r_ovf   <= 1'b1;
                end else begin
                    r_q     <= w_dec[WIDTH-1:0];
                    r_carry <= 1'b0;
                end
            end
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign q     = r_q;
    assign carry = r_carry;
    assign ovf   = r_ovf;
    assign tc    = up ? (r_q == LP_MAX_Q) : (r_q == '0);

endmodule : sync_updown_counter

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: wrap, saturate and prescaled instances share
// one stimulus set; expected values are hand-derived per step.
module tb_sync_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       t;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       clr;

    logic [3:0] q_w, q_s, q_p;
    logic       tc_w, tc_s, tc_p;
    logic       carry_w, carry_s, carry_p;
    logic       ovf_w, ovf_s, ovf_p;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .t(t), .up(up), .load(load), .din(din), .clr(clr),
        .q(q_w), .tc(tc_w), .carry(carry_w), .ovf(ovf_w)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .t(t), .up(up), .load(load), .din(din), .clr(clr),
        .q(q_s), .tc(tc_s), .carry(carry_s), .ovf(ovf_s)
    );

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) dut_pre (
        .clk(clk), .rst_n(rst_n), .t(t), .up(up), .load(load), .din(din), .clr(clr),
        .q(q_p), .tc(tc_p), .carry(carry_p), .ovf(ovf_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int exp_sat_q[4]  = '{1, 0, 0, 0};
        int exp_sat_c[4]  = '{0, 0, 1, 1};
        int exp_sat_tc[4] = '{0, 1, 1, 1};
        int exp_pre_q[9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

        rst_n = 1'b0; t = 1'b1; up = 1'b1; load = 1'b0; din = '0; clr = 1'b0;
        #2;

        // 1. Reset held with t=1 for three clocks.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_q[%0d]", i),     q_w,     0);
            check($sformatf("rst_carry[%0d]", i), carry_w, 0);
            check($sformatf("rst_ovf[%0d]", i),   ovf_w,   0);
            check($sformatf("rst_pre_q[%0d]", i), q_p,     0);
        end

        // 2. Wrap up for 12 clocks; saturating instance runs alongside.
        rst_n = 1'b1; t = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("wrap_q[%0d]", i),     q_w,     i % 10);
            check($sformatf("wrap_carry[%0d]", i), carry_w, (i == 10));
            check($sformatf("wrap_ovf[%0d]", i),   ovf_w,   (i >= 10));
            check($sformatf("wrap_tc[%0d]", i),    tc_w,    (i % 10 == 9));
            check($sformatf("satup_q[%0d]", i),    q_s,     (i < 9) ? i : 9);
            check($sformatf("satup_carry[%0d]", i), carry_s, (i >= 10));
        end

        // 3. Saturate down from a load of 2.
        t = 1'b0; load = 1'b1; din = 4'd2;
        step();
        check("sat_load_q", q_s, 2);
        load = 1'b0; t = 1'b1; up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("satdn_q[%0d]", i),     q_s,     exp_sat_q[i]);
            check($sformatf("satdn_carry[%0d]", i), carry_s, exp_sat_c[i]);
            check($sformatf("satdn_tc[%0d]", i),    tc_s,    exp_sat_tc[i]);
        end

        // 4. clr beats load and count; then an out-of-range load clamps.
        check("prio_ovf_before", ovf_w, 1);
        clr = 1'b1; load = 1'b1; din = 4'd5; t = 1'b1; up = 1'b1;
        step();
        check("prio_q",     q_w,     0);
        check("prio_ovf",   ovf_w,   0);
        check("prio_carry", carry_w, 0);
        clr = 1'b0; load = 1'b1; din = 4'd12; t = 1'b0;
        step();
        check("clamp_q",   q_w,  9);
        check("clamp_tc",  tc_w, 1);
        check("clamp_ovf", ovf_w, 0);

        // 5. Prescale by 3; a two-cycle enable gap must not reset the phase.
        load = 1'b0; clr = 1'b1; t = 1'b0;
        step();
        clr = 1'b0; t = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("pre_q[%0d]", i), q_p, exp_pre_q[i]);
        end
        step();
        check("pre_gap_in", q_p, 3);
        t = 1'b0;
        step();
        step();
        check("pre_gap_hold", q_p, 3);
        t = 1'b1;
        step();
        check("pre_resume_a", q_p, 3);
        step();
        check("pre_resume_b", q_p, 4);

        // 6. Reset mid-count at q=7 with the prescaler mid-phase.
        t = 1'b0; load = 1'b1; din = 4'd9;
        step();
        load = 1'b0; t = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("mid_q",     q_w,   7);
        check("mid_ovf",   ovf_w, 1);
        check("mid_pre_q", q_p,   1);
        rst_n = 1'b0;
        step();
        check("mid_rst_q",     q_w,   0);
        check("mid_rst_ovf",   ovf_w, 0);
        check("mid_rst_pre_q", q_p,   0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("restart_q[%0d]", i),     q_w, i);
            check($sformatf("restart_pre_q[%0d]", i), q_p, (i == 3) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_updown_counter
